mult_accum_pipe: RTL and testbench

- Parametrised, fully pipelined multiply-add-accumulate block for the elaborated arithmetic library.
- Takes NUM_MULT signed/unsigned operand pairs and forms products, then a pairwise add/subtract sum.
- Can accumulate the sum into a wide result register with synchronous load, and carries a valid flag.
- Clock-enable gated; replaces the fixed single-clock multiply-add primitive when mapping DSP-style operators.

---
 rtl/mult_accum_pkg.sv | 36 +++
 rtl/mult_accum_lane.sv | 44 ++++
 rtl/mult_accum_pipe.sv | 137 +++++++++++++
 tb/tb_mult_accum_pipe.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_accum_pkg.sv
// Shared types and constant helpers for the mult_accum_pipe multiply-add-accumulate block.
package mult_accum_pkg;

    localparam int SAT_W = 256;

    typedef logic [SAT_W-1:0] sat_word_t;

    // One valid flag per pipeline stage; s4 is the registered out_valid.
    typedef struct packed {
        logic s4;
        logic s3;
        logic s2;
        logic s1;
    } stage_vld_t;

    function automatic int prod_width(input int wa, input int wb);
        return wa + wb + 2;
    endfunction

    function automatic sat_word_t sat_max(input int w);
        sat_word_t v;
        v = '0;
        for (int i = 0; i < w - 1; i++) begin
            v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic sat_word_t sat_min(input int w);
        sat_word_t v;
        v = '0;
        v[w-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mult_accum_lane.sv
// One multiplier lane: operand sign extension, S1 operand register, S2 exact product register.
module mult_accum_lane
    import mult_accum_pkg::*;
#(
    parameter int WA = 18,
    parameter int WB = 18,
    parameter int PW = prod_width(WA, WB)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic [WA-1:0]        a_i,
    input  logic [WB-1:0]        b_i,
    input  logic                 signa_i,
    input  logic                 signb_i,
    output logic signed [PW-1:0] prod_o
);

    logic signed [WA:0]   a_q, a_d;
    logic signed [WB:0]   b_q, b_d;
    logic signed [PW-1:0] p_q, p_d;

    // The extra bit makes unsigned operands non-negative in a signed multiply.
    always_comb begin
        a_d = {signa_i & a_i[WA-1], a_i};
        b_d = {signb_i & b_i[WB-1], b_i};
        p_d = PW'(a_q) * PW'(b_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            a_q <= '0;
            b_q <= '0;
            p_q <= '0;
        end else if (en_i) begin
            a_q <= a_d;
            b_q <= b_d;
            p_q <= p_d;
        end
    end

    assign prod_o = p_q;

endmodule

// File: rtl/mult_accum_pipe.sv
// Four-stage pipelined multiply, pairwise add/sub, sum and optional accumulate.
// Define MULT_ACCUM_SATURATE_EN to clamp an overflowing accumulate instead of wrapping.
module mult_accum_pipe
    import mult_accum_pkg::*;
#(
    parameter int NUM_MULT     = 2,
    parameter int WIDTH_A      = 18,
    parameter int WIDTH_B      = 18,
    parameter int WIDTH_RESULT = 44,
    parameter int ACCUM_MODE   = 0
) (
    input  logic                         clock0,
    input  logic                         sclr0_n,
    input  logic                         ena0,
    input  logic                         in_valid,
    input  logic [WIDTH_A*NUM_MULT-1:0]  dataa,
    input  logic [WIDTH_B*NUM_MULT-1:0]  datab,
    input  logic                         signa,
    input  logic                         signb,
    input  logic                         addnsub1,
    input  logic                         addnsub3,
    input  logic                         accum_sload,
    output logic [WIDTH_RESULT-1:0]      result,
    output logic                         out_valid,
    output logic                         overflow
);

    localparam int PW  = prod_width(WIDTH_A, WIDTH_B);
    localparam int MSB = WIDTH_RESULT - 1;

`ifdef MULT_ACCUM_SATURATE_EN
    localparam sat_word_t              SAT_MAX_W = sat_max(WIDTH_RESULT);
    localparam sat_word_t              SAT_MIN_W = sat_min(WIDTH_RESULT);
    localparam logic [WIDTH_RESULT-1:0] SAT_MAX_R = SAT_MAX_W[WIDTH_RESULT-1:0];
    localparam logic [WIDTH_RESULT-1:0] SAT_MIN_R = SAT_MIN_W[WIDTH_RESULT-1:0];
`endif

    logic signed [PW-1:0] prod [4];

    for (genvar g = 0; g < 4; g++) begin : g_lane
        if (g < NUM_MULT) begin : g_used
            mult_accum_lane #(
                .WA (WIDTH_A),
                .WB (WIDTH_B),
                .PW (PW)
            ) u_lane (
                .clk_i   (clock0),
                .rst_n_i (sclr0_n),
                .en_i    (ena0),
                .a_i     (dataa[g*WIDTH_A +: WIDTH_A]),
                .b_i     (datab[g*WIDTH_B +: WIDTH_B]),
                .signa_i (signa),
                .signb_i (signb),
                .prod_o  (prod[g])
            );
        end else begin : g_absent
            assign prod[g] = '0;
        end
    end

    // Control pipe bits: {sload, addnsub3, addnsub1}.
    stage_vld_t              vld_q, vld_d;
    logic [2:0]              s1_ctl_q, s2_ctl_q;
    logic                    s3_sload_q;
    logic [WIDTH_RESULT-1:0] s01_q, s01_d, s23_q, s23_d;
    logic [WIDTH_RESULT-1:0] acc_q, acc_d;
    logic                    ovf_q, ovf_d;

    logic signed [WIDTH_RESULT-1:0] px [4];
    logic [WIDTH_RESULT-1:0]        total_r;
    logic [WIDTH_RESULT-1:0]        sum_r;
    logic                           add_ovf;

    // WIDTH_RESULT >= PW, so widening here is exact; the sums then wrap mod 2^WIDTH_RESULT,
    // which equals computing wide and keeping the LSBs.
    always_comb begin
        vld_d.s1 = in_valid;
        vld_d.s2 = vld_q.s1;
        vld_d.s3 = vld_q.s2;
        vld_d.s4 = vld_q.s3;

        for (int i = 0; i < 4; i++) begin
            px[i] = WIDTH_RESULT'(prod[i]);
        end
        s01_d = s2_ctl_q[0] ? px[0] + px[1] : px[0] - px[1];
        s23_d = s2_ctl_q[1] ? px[2] + px[3] : px[2] - px[3];

        total_r = s01_q + s23_q;
        sum_r   = acc_q + total_r;
        add_ovf = (acc_q[MSB] == total_r[MSB]) && (sum_r[MSB] != acc_q[MSB]);

        acc_d = acc_q;
        ovf_d = ovf_q;
        if (vld_q.s3) begin
            if (ACCUM_MODE == 0 || s3_sload_q) begin
                acc_d = total_r;
                ovf_d = 1'b0;
            end else begin
                acc_d = sum_r;
                ovf_d = add_ovf;
`ifdef MULT_ACCUM_SATURATE_EN
                if (add_ovf) begin
                    acc_d = acc_q[MSB] ? SAT_MIN_R : SAT_MAX_R;
                end
`endif
            end
        end
    end

    always_ff @(posedge clock0) begin
        if (!sclr0_n) begin
            vld_q      <= '0;
            s1_ctl_q   <= '0;
            s2_ctl_q   <= '0;
            s3_sload_q <= 1'b0;
            s01_q      <= '0;
            s23_q      <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else if (ena0) begin
            vld_q      <= vld_d;
            s1_ctl_q   <= {accum_sload, addnsub3, addnsub1};
            s2_ctl_q   <= s1_ctl_q;
            s3_sload_q <= s2_ctl_q[2];
            s01_q      <= s01_d;
            s23_q      <= s23_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
        end
    end

    // The result register doubles as the accumulator.
    assign result    = acc_q;
    assign out_valid = vld_q.s4;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_mult_accum_pipe.sv
// Bench for mult_accum_pipe: an accumulating 4-lane instance and a sum-only 2-lane instance share stimulus.
module tb_mult_accum_pipe;

  localparam int     WR_A  = 18;
  localparam int     WR_S  = 20;
  localparam longint MAX_A = 131071;
  localparam longint MIN_A = -131072;

  // clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        sclr0_n = 1'b0;
  logic        ena0 = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;
  logic        signa = 1'b0, signb = 1'b0;
  logic        addnsub1 = 1'b1, addnsub3 = 1'b1, accum_sload = 1'b0;

  logic [WR_A-1:0] result_a;
  logic            vld_a, ovf_a;
  logic [WR_S-1:0] result_s;
  logic            vld_s, ovf_s;

  mult_accum_pipe #(
    .NUM_MULT(4), .WIDTH_A(8), .WIDTH_B(8), .WIDTH_RESULT(WR_A), .ACCUM_MODE(1)
  ) dut_a (
    .clock0(clk), .sclr0_n(sclr0_n), .ena0(ena0), .in_valid(in_valid),
    .dataa(dataa), .datab(datab), .signa(signa), .signb(signb),
    .addnsub1(addnsub1), .addnsub3(addnsub3), .accum_sload(accum_sload),
    .result(result_a), .out_valid(vld_a), .overflow(ovf_a)
  );

  mult_accum_pipe #(
    .NUM_MULT(2), .WIDTH_A(8), .WIDTH_B(8), .WIDTH_RESULT(WR_S), .ACCUM_MODE(0)
  ) dut_s (
    .clock0(clk), .sclr0_n(sclr0_n), .ena0(ena0), .in_valid(in_valid),
    .dataa(dataa[15:0]), .datab(datab[15:0]), .signa(signa), .signb(signb),
    .addnsub1(addnsub1), .addnsub3(addnsub3), .accum_sload(accum_sload),
    .result(result_s), .out_valid(vld_s), .overflow(ovf_s)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state and scoreboard: entries are {overflow, result}
  longint        acc_m = 0;
  logic [WR_A:0] exp_a_q[$];
  logic [WR_S:0] exp_s_q[$];
  logic [WR_A:0] last_a = '0, e_a;
  logic [WR_S:0] last_s = '0, e_s;
  logic [WR_A+1:0] prev_a = '0;
  logic [WR_S+1:0] prev_s = '0;
  bit   mon_on = 1'b0;
  logic rst_seen = 1'b0, ena_seen = 1'b0;

  function automatic longint wrap(input longint v, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = v & (m - 1);
    if (r >= (m >>> 1)) r = r - m;
    return r;
  endfunction

  function automatic longint lane_prod(input logic [7:0] a, input logic [7:0] b, input bit sa, input bit sb);
    longint x, y;
    x = sa ? longint'($signed(a)) : longint'(a);
    y = sb ? longint'($signed(b)) : longint'(b);
    return x * y;
  endfunction

  function automatic longint beat_total(input logic [31:0] a, input logic [31:0] b, input bit sa, input bit sb,
                                        input bit ad1, input bit ad3, input int lanes);
    longint p[4];
    for (int i = 0; i < 4; i++) p[i] = (i < lanes) ? lane_prod(a[i*8 +: 8], b[i*8 +: 8], sa, sb) : 0;
    return (ad1 ? p[0] + p[1] : p[0] - p[1]) + (ad3 ? p[2] + p[3] : p[2] - p[3]);
  endfunction

  // driver tasks
  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit sa, input bit sb,
                      input bit ad1, input bit ad3, input bit sl);
    longint ta, ts, raw;
    bit ov;
    @(posedge clk); #1;
    ena0 = 1'b1; in_valid = 1'b1;
    dataa = a; datab = b; signa = sa; signb = sb;
    addnsub1 = ad1; addnsub3 = ad3; accum_sload = sl;
    ta = wrap(beat_total(a, b, sa, sb, ad1, ad3, 4), WR_A);
    ts = wrap(beat_total(a, b, sa, sb, ad1, ad3, 2), WR_S);
    ov = 1'b0;
    if (sl) begin
      acc_m = ta;
    end else begin
      raw = acc_m + ta;
      ov  = (raw > MAX_A) || (raw < MIN_A);
`ifdef MULT_ACCUM_SATURATE_EN
      if (ov) acc_m = (raw > 0) ? MAX_A : MIN_A;
      else    acc_m = raw;
`else
      acc_m = wrap(raw, WR_A);
`endif
    end
    exp_a_q.push_back({ov, acc_m[WR_A-1:0]});
    exp_s_q.push_back({1'b0, ts[WR_S-1:0]});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ena0 = 1'b1; in_valid = 1'b0;
      dataa = $urandom; datab = $urandom; accum_sload = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ena0 = 1'b0; in_valid = 1'($urandom_range(0, 1));
      dataa = $urandom; datab = $urandom;
    end
  endtask

  // scoreboard / monitor
  always @(posedge clk) begin
    rst_seen <= sclr0_n;
    ena_seen <= ena0;
  end

  always @(negedge clk) begin
    if (mon_on && rst_seen) begin
      if (!ena_seen) begin
        n_vec++;
        if ({vld_a, ovf_a, result_a} !== prev_a) begin
          n_err++; $display("FAIL frozen_a got %h exp %h", {vld_a, ovf_a, result_a}, prev_a);
        end
        n_vec++;
        if ({vld_s, ovf_s, result_s} !== prev_s) begin
          n_err++; $display("FAIL frozen_s got %h exp %h", {vld_s, ovf_s, result_s}, prev_s);
        end
      end else begin
        n_vec++;
        if (vld_a === 1'b1) begin
          if (exp_a_q.size() == 0) begin
            n_err++; $display("FAIL unexpected_valid_a got result %h", result_a);
          end else begin
            e_a = exp_a_q.pop_front();
            if ({ovf_a, result_a} !== e_a) begin
              n_err++; $display("FAIL beat_a got ovf=%b res=%0d exp ovf=%b res=%0d",
                                ovf_a, $signed(result_a), e_a[WR_A], $signed(e_a[WR_A-1:0]));
            end
            last_a = e_a;
          end
        end else if ({vld_a, ovf_a, result_a} !== {1'b0, last_a}) begin
          n_err++; $display("FAIL hold_a got %h exp %h", {vld_a, ovf_a, result_a}, {1'b0, last_a});
        end
        n_vec++;
        if (vld_s === 1'b1) begin
          if (exp_s_q.size() == 0) begin
            n_err++; $display("FAIL unexpected_valid_s got result %h", result_s);
          end else begin
            e_s = exp_s_q.pop_front();
            if ({ovf_s, result_s} !== e_s) begin
              n_err++; $display("FAIL beat_s got ovf=%b res=%0d exp ovf=%b res=%0d",
                                ovf_s, $signed(result_s), e_s[WR_S], $signed(e_s[WR_S-1:0]));
            end
            last_s = e_s;
          end
        end else if ({vld_s, ovf_s, result_s} !== {1'b0, last_s}) begin
          n_err++; $display("FAIL hold_s got %h exp %h", {vld_s, ovf_s, result_s}, {1'b0, last_s});
        end
      end
    end
    prev_a = {vld_a, ovf_a, result_a};
    prev_s = {vld_s, ovf_s, result_s};
  end

  task automatic clear_model();
    acc_m = 0;
    exp_a_q.delete();
    exp_s_q.delete();
    last_a = '0;
    last_s = '0;
  endtask

  // Reset with ena0 low: reset must win over the enable.
  task automatic test_reset();
    sclr0_n = 1'b0; ena0 = 1'b0; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({vld_a, ovf_a, result_a} !== 20'd0) begin
      n_err++; $display("FAIL reset_a got %h exp 0", {vld_a, ovf_a, result_a});
    end
    n_vec++;
    if ({vld_s, ovf_s, result_s} !== 22'd0) begin
      n_err++; $display("FAIL reset_s got %h exp 0", {vld_s, ovf_s, result_s});
    end
    @(posedge clk); #1;
    sclr0_n = 1'b1; ena0 = 1'b1; in_valid = 1'b0;
    clear_model();
    mon_on = 1'b1;
  endtask

  // a=(3,5) b=(7,11) unsigned add: 76, out_valid exactly on the 4th edge, one cycle wide.
  task automatic test_latency();
    send(32'h0000_0503, 32'h0000_0B07, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (vld_s !== (k == 4)) begin
        n_err++; $display("FAIL latency_valid cycle %0d got %b exp %b", k, vld_s, (k == 4));
      end
      if (k == 4) begin
        n_vec++;
        if (longint'($signed(result_s)) != 76) begin
          n_err++; $display("FAIL sum_basic got %0d exp 76", $signed(result_s));
        end
      end
    end
    idle(2);
  endtask

  // Signed -4*6 - 2*3 = -30.
  task automatic test_signed();
    send(32'h0000_02FC, 32'h0000_0306, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1);
    repeat (4) @(negedge clk);
    n_vec++;
    if (vld_s !== 1'b1 || longint'($signed(result_s)) != -30) begin
      n_err++; $display("FAIL signed_sub got v=%b res=%0d exp v=1 res=-30", vld_s, $signed(result_s));
    end
    n_vec++;
    if (vld_a !== 1'b1 || longint'($signed(result_a)) != -30) begin
      n_err++; $display("FAIL signed_sub_acc got v=%b res=%0d exp v=1 res=-30", vld_a, $signed(result_a));
    end
    idle(3);
  endtask

  // Back-to-back totals 10,20,30 (load first) then load 5: 10,30,60,5 on consecutive cycles.
  task automatic test_accum();
    longint want[4] = '{10, 30, 60, 5};
    send(32'd10, 32'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send(32'd20, 32'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send(32'd30, 32'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send(32'd5,  32'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (vld_a !== 1'b1 || longint'($signed(result_a)) != want[i]) begin
        n_err++; $display("FAIL accum_seq[%0d] got v=%b res=%0d exp v=1 res=%0d", i, vld_a, $signed(result_a), want[i]);
      end
    end
    idle(3);
  endtask

  // Enable dropped for 3 cycles while results are emerging.
  task automatic test_enable();
    for (int i = 0; i < 5; i++)
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, (i == 0));
    stall(3);
    for (int i = 0; i < 3; i++)
      send($urandom, $urandom, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(8);
  endtask

  // Reset for one cycle with three beats in flight; they must vanish.
  task automatic test_reset_inflight();
    for (int i = 0; i < 3; i++)
      send($urandom, $urandom, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    sclr0_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    sclr0_n = 1'b1;
    clear_model();
    @(negedge clk);
    n_vec++;
    if ({vld_a, ovf_a, result_a} !== 20'd0) begin
      n_err++; $display("FAIL flush_a got %h exp 0", {vld_a, ovf_a, result_a});
    end
    n_vec++;
    if ({vld_s, ovf_s, result_s} !== 22'd0) begin
      n_err++; $display("FAIL flush_s got %h exp 0", {vld_s, ovf_s, result_s});
    end
    send(32'd7, 32'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
    repeat (4) @(negedge clk);
    n_vec++;
    if (vld_a !== 1'b1 || longint'($signed(result_a)) != 7) begin
      n_err++; $display("FAIL post_reset_acc got v=%b res=%0d exp v=1 res=7", vld_a, $signed(result_a));
    end
    idle(3);
  endtask

  // Four lanes of 127*127 (64516 per beat) into an 18-bit accumulator; the 3rd beat overflows.
  task automatic test_overflow();
`ifdef MULT_ACCUM_SATURATE_EN
    longint want[4] = '{64516, 129032, 131071, 131070};
`else
    longint want[4] = '{64516, 129032, -68596, -68597};
`endif
    bit want_ovf[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    send(32'h7F7F_7F7F, 32'h7F7F_7F7F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send(32'h7F7F_7F7F, 32'h7F7F_7F7F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send(32'h7F7F_7F7F, 32'h7F7F_7F7F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send(32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (vld_a !== 1'b1 || ovf_a !== want_ovf[i] || longint'($signed(result_a)) != want[i]) begin
        n_err++; $display("FAIL overflow_seq[%0d] got v=%b ovf=%b res=%0d exp v=1 ovf=%b res=%0d",
                          i, vld_a, ovf_a, $signed(result_a), want_ovf[i], want[i]);
      end
    end
    idle(4);
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)
        send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      else if (r < 8)
        idle(1);
      else
        stall($urandom_range(1, 2));
    end
    idle(8);
  endtask

  // final report
  initial begin
    test_reset();
    test_latency();
    test_signed();
    test_accum();
    test_enable();
    test_reset_inflight();
    test_overflow();
    test_random();
    idle(8);
    n_vec++;
    if (exp_a_q.size() != 0) begin
      n_err++; $display("FAIL drain_a got %0d pending exp 0", exp_a_q.size());
    end
    n_vec++;
    if (exp_s_q.size() != 0) begin
      n_err++; $display("FAIL drain_s got %0d pending exp 0", exp_s_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
